// File: rtl/lfsr_pkg.sv
// Shared definitions for LFSR-based generators: FSM states, default
// feedback masks and the Fibonacci step function.
package lfsr_pkg;

    // Widest LFSR the shared step function supports
    localparam int MAX_WIDTH = 64;

    // Maximal-length feedback masks; bit i set means state[i] feeds the XOR.
    // The polynomial term x^e maps to mask bit e-1.
    localparam logic [7:0]  TAPS_8  = 8'hB8;     // x^8+x^6+x^5+x^4+1
    localparam logic [12:0] TAPS_13 = 13'h100D;  // x^13+x^4+x^3+x+1
    localparam logic [15:0] TAPS_16 = 16'hD008;  // x^16+x^15+x^13+x^4+1

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        COUNT = 2'd2
    } state_e;

    // One Fibonacci step: feedback is the parity of the tapped bits, shifted
    // in at bit 0; the result is masked back down to the real width.
    function automatic logic [MAX_WIDTH-1:0] lfsr_next(
        input logic [MAX_WIDTH-1:0] state,
        input logic [MAX_WIDTH-1:0] taps,
        input int                   width
    );
        logic                 fb;
        logic [MAX_WIDTH-1:0] mask;
        fb   = ^(state & taps);
        mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
        return ((state << 1) | {{(MAX_WIDTH-1){1'b0}}, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Reusable LFSR register: synchronous load (never entering the all-zero
// lockup state) and single-step advance on enable.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 13,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             enable,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    // Next register value: load wins over a step; a zero seed becomes 1
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (enable) begin
            lfsr_d = WIDTH'(lfsr_next(MAX_WIDTH'(lfsr_q), MAX_WIDTH'(TAPS), WIDTH));
        end
    end

    // State register, reset to the non-zero value 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= WIDTH'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/lfsr_rng.sv
// Request-driven random value / random delay generator for the reaction
// timer. Each accepted start optionally reseeds, advances STEPS times,
// publishes the value and, in mode 1, counts down a delay derived from it.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 13,
    parameter logic [WIDTH-1:0] TAPS       = TAPS_13,
    parameter int               STEPS      = 4,
    parameter logic [WIDTH-1:0] DELAY_MASK = 13'h000F,
    parameter int               MIN_DELAY  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rnd
);

    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH:0]    dcnt_q, dcnt_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  rnd_q, rnd_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;

    logic              core_load;
    logic              core_enable;
    logic [WIDTH-1:0]  lfsr_state;
    logic [WIDTH-1:0]  lfsr_step;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .seed   (seed),
        .enable (core_enable),
        .state  (lfsr_state)
    );

    // Value the core will hold after the shift happening this cycle
    assign lfsr_step = WIDTH'(lfsr_next(MAX_WIDTH'(lfsr_state), MAX_WIDTH'(TAPS), WIDTH));

    // Request FSM: accept, shift STEPS times, optionally count down, complete
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        dcnt_d      = dcnt_q;
        mode_d      = mode_q;
        rnd_d       = rnd_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        core_load   = 1'b0;
        core_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                // The completion cycle also sits in IDLE; starts are refused there
                if (start && !valid_q) begin
                    core_load = load;
                    mode_d    = mode;
                    step_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                core_enable = 1'b1;
                if (step_q == STEP_W'(STEPS - 1)) begin
                    rnd_d = lfsr_step;
                    if (!mode_q) begin
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        dcnt_d  = {1'b0, lfsr_step & DELAY_MASK} + (WIDTH+1)'(MIN_DELAY);
                        state_d = COUNT;
                    end
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            COUNT: begin
                if (dcnt_q == '0) begin
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    dcnt_d = dcnt_q - (WIDTH+1)'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers; reset overrides any request in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            dcnt_q  <= '0;
            mode_q  <= 1'b0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dcnt_q  <= dcnt_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign rnd   = rnd_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed self-checking bench for lfsr_rng with default parameters.
module tb_lfsr_rng;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        load;
    logic [12:0] seed;
    logic        mode;
    logic        busy;
    logic        valid;
    logic [12:0] rnd;

    int assertion_count = 0;
    int fail_count      = 0;

    lfsr_rng dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .load  (load),
        .seed  (seed),
        .mode  (mode),
        .busy  (busy),
        .valid (valid),
        .rnd   (rnd)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertion_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one request and follow it to completion. Inputs change and
    // outputs are sampled on falling edges. When poke is set, start is
    // pulsed (with a reseed to 0x1234) during SHIFT, COUNT and the valid
    // cycle; all of those must be ignored.
    task automatic applyStimulus(input string tag, input logic ld, input logic [12:0] sd,
                                 input logic md, input bit poke,
                                 input int exp_edges, input logic [12:0] exp_rnd);
        int edges;
        bit busy_dropped;
        @(negedge clk);
        start = 1'b1;
        load  = ld;
        seed  = sd;
        mode  = md;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        seed  = '0;
        mode  = 1'b0;
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
        edges = 0;
        busy_dropped = 1'b0;
        while (!valid && edges < 300) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (!valid && !busy) busy_dropped = 1'b1;
            if (poke && (edges == 1 || edges == 8)) begin
                start = 1'b1;
                load  = 1'b1;
                seed  = 13'h1234;
            end else begin
                start = 1'b0;
                load  = 1'b0;
                seed  = '0;
            end
        end
        checkOutput({tag, " edges to valid"}, 32'(edges), 32'(exp_edges));
        checkOutput({tag, " rnd"}, 32'(rnd), 32'(exp_rnd));
        checkOutput({tag, " busy in valid cycle"}, 32'(busy), 32'd0);
        checkOutput({tag, " busy held"}, 32'(busy_dropped), 32'd0);
        if (poke) begin
            start = 1'b1;
            load  = 1'b1;
            seed  = 13'h1234;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        seed  = '0;
        checkOutput({tag, " valid one cycle"}, 32'(valid), 32'd0);
        checkOutput({tag, " idle after valid"}, 32'(busy), 32'd0);
        checkOutput({tag, " rnd held"}, 32'(rnd), 32'(exp_rnd));
    endtask

    initial begin
        int   edges;
        logic saw_valid;
        rst_n = 1'b0;
        start = 1'b0;
        load  = 1'b0;
        seed  = '0;
        mode  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rnd", 32'(rnd), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset valid", 32'(valid), 32'd0);
        rst_n = 1'b1;

        // Seed 1: 1 -> 3 -> 7 -> E -> 1C
        applyStimulus("seed1 mode0", 1'b1, 13'h0001, 1'b0, 1'b0, 4, 13'h001C);
        // Continue: 38 -> 71 -> E3 -> 1C7
        applyStimulus("continue", 1'b0, 13'h0000, 1'b0, 1'b0, 4, 13'h01C7);
        // Zero seed behaves as seed 1
        applyStimulus("zero seed", 1'b1, 13'h0000, 1'b0, 1'b0, 4, 13'h001C);
        // Delay mode: D = (0x1C & 0xF) + 2 = 14, valid after E19; starts ignored
        applyStimulus("delay mode", 1'b1, 13'h0001, 1'b1, 1'b1, 19, 13'h001C);
        // Ignored pokes must not have reseeded: continue from 0x1C
        applyStimulus("after pokes", 1'b0, 13'h0000, 1'b0, 1'b0, 4, 13'h01C7);

        // Reset in the middle of a countdown
        @(negedge clk);
        start = 1'b1;
        load  = 1'b1;
        seed  = 13'h0001;
        mode  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        mode  = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("busy before mid reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset valid", 32'(valid), 32'd0);
        checkOutput("mid reset rnd", 32'(rnd), 32'h0);
        saw_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) saw_valid = 1'b1;
        end
        checkOutput("no valid after reset", 32'(saw_valid), 32'd0);
        // lfsr is back at 1, so a non-loading request yields 0x1C
        applyStimulus("post reset", 1'b0, 13'h0000, 1'b0, 1'b0, 4, 13'h001C);

        edges = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
        $finish;
    end

endmodule
